// File: rtl/regwb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Holds the default data/address widths, the register count, the queued
// write-back entry type and a one-hot decode helper used by the busy mask.
package regwb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  // One pending register-file write: destination register and its value.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot decode of a register index into a NUM_REGS-wide mask.
  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [DEF_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two result producers, the register-file write port
// and the write-back arbiter.
//   ld_*      : load unit result handshake (valid/rd/data in, ready out)
//   alu_*     : ALU result handshake (valid/rd/data in, ready out)
//   wr_stall  : register-file write port unavailable
//   wr_*      : RegWrite / RDo / Mem_to_Reg drive
//   reg_busy  : per-register pending-write mask for decode
// The arbiter connects through the slave modport, its environment through master.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);

  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [(2**ADDR_W)-1:0] reg_busy;

  modport slave (
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  wr_stall,
    output wr_en, wr_addr, wr_data,
    output reg_busy
  );

  modport master (
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output wr_stall,
    input  wr_en, wr_addr, wr_data,
    input  reg_busy
  );

endinterface

// File: rtl/regwb_fifo.sv
// Dual-push, single-pop circular FIFO of write-back entries.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push0/push0_entry   : first push slot (enqueued first)
//   push1/push1_entry   : second push slot (enqueued behind push0)
//   pop                 : remove the head entry
//   head                : current head entry
//   count               : registered occupancy (0..DEPTH)
//   entry_valid/rd      : per-slot occupancy and destination for the busy mask
// The caller guarantees no push beyond DEPTH and no pop when empty.
module regwb_fifo
  import regwb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push0,
  input  wb_entry_t             push0_entry,
  input  logic                  push1,
  input  wb_entry_t             push1_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      count,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [DEF_ADDR_W-1:0] entry_rd [DEPTH]
);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wptr_r;
  logic [PTR_W-1:0] rptr_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] wptr1_s;

  // push1 lands right after push0 when both fire, else at the write pointer.
  assign wptr1_s = wptr_r + PTR_W'(push0);

  // Entry storage; contents are don't-care until marked valid by count.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_r[wptr_r] <= push0_entry;
    end
    if (push1) begin
      mem_r[wptr1_s] <= push1_entry;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      wptr_r  <= wptr_r + PTR_W'(push0) + PTR_W'(push1);
      rptr_r  <= rptr_r + PTR_W'(pop);
      count_r <= count_r + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin : slot_decode
    logic [PTR_W-1:0] offset;
    offset = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rptr_r;
      entry_valid[i] = ({1'b0, offset} < count_r);
      entry_rd[i]    = mem_r[i].rd;
    end
  end

  assign head  = mem_r[rptr_r];
  assign count = count_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and buffer for the register file's single write port.
// Accepts results from the load unit and the ALU (load wins ordering when
// both transfer together), drops writes to r0, queues the rest in a small
// FIFO and drains one entry per cycle onto RegWrite/RDo/Mem_to_Reg.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_wb_arbiter_if slave modport (producers, write port,
//                reg_busy mask)
// Build option REGWB_SCOREBOARD_EN: when defined, reg_busy marks every
// register with a queued or in-flight write; when undefined reg_busy is 0.
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_W;

  logic              ld_ready_s;
  logic              alu_ready_s;
  logic              push0_s;
  logic              push1_s;
  logic              pop_s;
  wb_entry_t         push0_entry_s;
  wb_entry_t         push1_entry_s;
  wb_entry_t         head_s;
  logic [CNT_W-1:0]  count_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [NREG-1:0]   busy_s;

  // Readies from registered occupancy only; ALU needs two free slots when
  // the load unit is also offering, so the pair never overflows the FIFO.
  always_comb begin
    ld_ready_s  = 1'b0;
    alu_ready_s = 1'b0;
    if (!rst_n) begin
      ld_ready_s  = 1'b0;
      alu_ready_s = 1'b0;
    end else begin
      ld_ready_s = (count_s <= CNT_W'(DEPTH - 1));
      if (bus.ld_valid) begin
        alu_ready_s = (count_s <= CNT_W'(DEPTH - 2));
      end else begin
        alu_ready_s = (count_s <= CNT_W'(DEPTH - 1));
      end
    end
  end

  // Completed transfers to r0 are acknowledged but never enqueued.
  assign push0_s       = bus.ld_valid  & ld_ready_s  & (bus.ld_rd  != {ADDR_W{1'b0}});
  assign push1_s       = bus.alu_valid & alu_ready_s & (bus.alu_rd != {ADDR_W{1'b0}});
  assign push0_entry_s = {bus.ld_rd, bus.ld_data};
  assign push1_entry_s = {bus.alu_rd, bus.alu_data};
  assign pop_s         = (count_s != {CNT_W{1'b0}}) & ~bus.wr_stall;

  `ifdef REGWB_SCOREBOARD_EN
  logic [DEPTH-1:0]      entry_valid_s;
  logic [DEF_ADDR_W-1:0] entry_rd_s [DEPTH];
  `else
  logic [DEPTH-1:0]      unused_entry_valid_s;
  logic [DEF_ADDR_W-1:0] unused_entry_rd_s [DEPTH];
  `endif

  regwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push0       (push0_s),
    .push0_entry (push0_entry_s),
    .push1       (push1_s),
    .push1_entry (push1_entry_s),
    .pop         (pop_s),
    .head        (head_s),
    .count       (count_s),
  `ifdef REGWB_SCOREBOARD_EN
    .entry_valid (entry_valid_s),
    .entry_rd    (entry_rd_s)
  `else
    .entry_valid (unused_entry_valid_s),
    .entry_rd    (unused_entry_rd_s)
  `endif
  );

  // Write-port registers: wr_en pulses per pop, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= {ADDR_W{1'b0}};
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      wr_en_r <= pop_s;
      if (pop_s) begin
        wr_addr_r <= head_s.rd;
        wr_data_r <= head_s.data;
      end
    end
  end

  `ifdef REGWB_SCOREBOARD_EN
  // Busy mask: every live FIFO entry plus the write currently on the port.
  always_comb begin
    busy_s = {NREG{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid_s[i]) begin
        busy_s = busy_s | rd_onehot(entry_rd_s[i]);
      end else begin
        busy_s = busy_s;
      end
    end
    if (wr_en_r) begin
      busy_s = busy_s | rd_onehot(wr_addr_r);
    end else begin
      busy_s = busy_s;
    end
    busy_s[0] = 1'b0;
  end
  `else
  assign busy_s = {NREG{1'b0}};
  `endif

  assign bus.ld_ready  = ld_ready_s;
  assign bus.alu_ready = alu_ready_s;
  assign bus.wr_en     = wr_en_r;
  assign bus.wr_addr   = wr_addr_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.reg_busy  = busy_s;

endmodule
